// File: rtl/fnd_apb_pkg.sv
// Shared types and constants for the FND APB arbiter slice.
//   state_t        : APB master sequencer states
//   FND_DATA_ADDR  : FND data register (4 BCD digits)
//   FND_CTRL_ADDR  : FND control register (bit0 = scan enable)
//   FND_WORD_W     : width of one client display word
package fnd_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [3:0] FND_DATA_ADDR = 4'h0;
  localparam logic [3:0] FND_CTRL_ADDR = 4'h4;
  localparam int         FND_WORD_W    = 16;

endpackage

// File: rtl/fnd_rr_arbiter.sv
// Combinational round-robin pick: returns the first asserted request found
// when scanning upward from rr_ptr, wrapping from NUM_REQ-1 back to 0.
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  IDX_W    index with highest priority this turn
//   any_valid out 1        at least one request asserted
//   idx       out IDX_W    chosen index (0 when any_valid is low)
module fnd_rr_arbiter
  import fnd_apb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any_valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan offsets from farthest to nearest so the nearest valid one wins.
  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    any_valid = 1'b0;
    idx       = '0;
    sum       = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        any_valid = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/fnd_apb_arbiter.sv
// APB master sharing the FND 7-segment peripheral between NUM_REQ clients.
// Pending 16-bit BCD words are granted round-robin and written to the FND
// data register; the control register is rewritten whenever disp_en differs
// from the last value written (and once after reset).
//   PCLK, PRESET      clock, synchronous active-high reset
//   req_valid/data    per-client pending word, word i at [16i+15:16i]
//   req_ready         one-cycle completion strobe per client (combinational)
//   disp_en           desired FND scan enable
//   PADDR..PREADY     APB master port towards the FND slave
//   grant_id          index of last/current data grant
//   busy              transfer in progress
//   err               one-cycle pulse when PREADY times out
module fnd_apb_arbiter
  import fnd_apb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [FND_WORD_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          disp_en,
  output logic [3:0]                    PADDR,
  output logic [31:0]                   PWDATA,
  output logic                          PWRITE,
  output logic                          PSEL,
  output logic                          PENABLE,
  input  logic                          PREADY,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_d;
  logic             psel_d, penable_d, pwrite_d, busy_d, err_d;
  logic [3:0]       paddr_d;
  logic [31:0]      pwdata_d;
  logic [IDX_W-1:0] cur_grant, cur_grant_d;
  logic             cur_is_data, cur_is_data_d;
  logic [IDX_W-1:0] rr_ptr, rr_ptr_d;
  logic             ctrl_pending, ctrl_pending_d;
  logic             en_shadow, en_shadow_d;
  logic [CNT_W-1:0] acc_cnt, acc_cnt_d;
  logic             ctrl_load;
  logic             arb_any;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W-1:0] grant_next;

  logic [FND_WORD_W-1:0] words [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = req_data[FND_WORD_W*g +: FND_WORD_W];
  end

  fnd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .any_valid (arb_any),
    .idx       (arb_idx)
  );

  // cur_grant doubles as the registered grant_id output.
  assign grant_id   = cur_grant;
  assign grant_next = (cur_grant == IDX_W'(NUM_REQ - 1)) ? '0 : cur_grant + IDX_W'(1);
  assign req_ready  = (state == ACCESS && PREADY && cur_is_data) ?
                      (NUM_REQ'(1) << cur_grant) : '0;

  always_comb begin
    state_d        = state;
    psel_d         = PSEL;
    penable_d      = PENABLE;
    pwrite_d       = PWRITE;
    paddr_d        = PADDR;
    pwdata_d       = PWDATA;
    busy_d         = busy;
    err_d          = 1'b0;
    cur_grant_d    = cur_grant;
    cur_is_data_d  = cur_is_data;
    rr_ptr_d       = rr_ptr;
    ctrl_pending_d = ctrl_pending;
    en_shadow_d    = en_shadow;
    acc_cnt_d      = acc_cnt;
    ctrl_load      = 1'b0;

    case (state)
      IDLE: begin
        if (ctrl_pending) begin
          // Control write wins over any data request.
          ctrl_load      = 1'b1;
          paddr_d        = FND_CTRL_ADDR;
          pwdata_d       = {31'b0, disp_en};
          cur_is_data_d  = 1'b0;
          en_shadow_d    = disp_en;
          ctrl_pending_d = 1'b0;
          psel_d         = 1'b1;
          penable_d      = 1'b0;
          pwrite_d       = 1'b1;
          busy_d         = 1'b1;
          state_d        = SETUP;
        end else if (arb_any) begin
          paddr_d       = FND_DATA_ADDR;
          pwdata_d      = {{(32-FND_WORD_W){1'b0}}, words[arb_idx]};
          cur_grant_d   = arb_idx;
          cur_is_data_d = 1'b1;
          psel_d        = 1'b1;
          penable_d     = 1'b0;
          pwrite_d      = 1'b1;
          busy_d        = 1'b1;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        acc_cnt_d = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY || acc_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Timeout also rotates the pointer so a stuck client cannot starve others.
          err_d     = !PREADY;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          pwrite_d  = 1'b0;
          busy_d    = 1'b0;
          state_d   = IDLE;
          if (cur_is_data) rr_ptr_d = grant_next;
        end else begin
          acc_cnt_d = acc_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Any mismatch outside a ctrl load schedules one write of the current value.
    if (!ctrl_load && disp_en != en_shadow) ctrl_pending_d = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state        <= IDLE;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      cur_grant    <= '0;
      cur_is_data  <= 1'b0;
      rr_ptr       <= '0;
      ctrl_pending <= 1'b1;
      en_shadow    <= 1'b0;
      acc_cnt      <= '0;
    end else begin
      state        <= state_d;
      PSEL         <= psel_d;
      PENABLE      <= penable_d;
      PWRITE       <= pwrite_d;
      PADDR        <= paddr_d;
      PWDATA       <= pwdata_d;
      busy         <= busy_d;
      err          <= err_d;
      cur_grant    <= cur_grant_d;
      cur_is_data  <= cur_is_data_d;
      rr_ptr       <= rr_ptr_d;
      ctrl_pending <= ctrl_pending_d;
      en_shadow    <= en_shadow_d;
      acc_cnt      <= acc_cnt_d;
    end
  end

endmodule

// File: tb/tb_fnd_apb_arbiter.sv
// Directed bench for fnd_apb_arbiter with a registered-PREADY FND slave model.
module tb_fnd_apb_arbiter;

  localparam int NUM_REQ = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [3:0]        req_valid;
  logic [63:0]       req_data;
  logic [3:0]        req_ready;
  logic              disp_en;
  logic [3:0]        PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic              PREADY;
  logic [1:0]        grant_id;
  logic              busy;
  logic              err;

  logic              hold;
  logic              fnd_en = 1'b0;
  int                checks = 0;
  int                failures = 0;

  fnd_apb_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .disp_en   (disp_en),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PREADY    (PREADY),
    .grant_id  (grant_id),
    .busy      (busy),
    .err       (err)
  );

  always #5 PCLK = ~PCLK;

  // FND slave: PREADY registered, one wait cycle per access; hold stalls it.
  always @(posedge PCLK) begin
    if (PRESET) begin
      PREADY <= 1'b0;
    end else begin
      PREADY <= !hold && PSEL && PENABLE && !PREADY;
      if (PSEL && PENABLE && PREADY && PWRITE && PADDR == 4'h4) fnd_en <= PWDATA[0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  // Called on the negedge of cycle 0; returns on the negedge of cycle 4.
  task automatic xfer(input string tag, input logic [3:0] a, input logic [31:0] d,
                      input int gid, input logic [3:0] rdy, input logic [3:0] drop,
                      input logic tog);
    @(negedge PCLK);
    chk({tag, "_c1_psel"},    32'(PSEL), 32'd1);
    chk({tag, "_c1_penable"}, 32'(PENABLE), 32'd0);
    chk({tag, "_c1_pwrite"},  32'(PWRITE), 32'd1);
    chk({tag, "_c1_paddr"},   32'(PADDR), 32'(a));
    chk({tag, "_c1_pwdata"},  PWDATA, d);
    chk({tag, "_c1_busy"},    32'(busy), 32'd1);
    chk({tag, "_c1_err"},     32'(err), 32'd0);
    chk({tag, "_c1_ready"},   32'(req_ready), 32'd0);
    if (a == 4'h0) chk({tag, "_grant"}, 32'(grant_id), 32'(gid));
    @(negedge PCLK);
    chk({tag, "_c2_psel"},    32'(PSEL), 32'd1);
    chk({tag, "_c2_penable"}, 32'(PENABLE), 32'd1);
    chk({tag, "_c2_paddr"},   32'(PADDR), 32'(a));
    chk({tag, "_c2_pwdata"},  PWDATA, d);
    chk({tag, "_c2_ready"},   32'(req_ready), 32'd0);
    if (tog) disp_en = ~disp_en;
    @(negedge PCLK);
    chk({tag, "_c3_penable"}, 32'(PENABLE), 32'd1);
    chk({tag, "_c3_ready"},   32'(req_ready), 32'(rdy));
    req_valid = req_valid & ~drop;
    @(negedge PCLK);
    chk({tag, "_c4_psel"},    32'(PSEL), 32'd0);
    chk({tag, "_c4_penable"}, 32'(PENABLE), 32'd0);
    chk({tag, "_c4_busy"},    32'(busy), 32'd0);
    chk({tag, "_c4_ready"},   32'(req_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    disp_en   = 1'b1;
    hold      = 1'b0;
    repeat (3) @(negedge PCLK);

    // Reset state
    chk("rst_psel",    32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite",  32'(PWRITE), 32'd0);
    chk("rst_paddr",   32'(PADDR), 32'd0);
    chk("rst_pwdata",  PWDATA, 32'd0);
    chk("rst_grant",   32'(grant_id), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_err",     32'(err), 32'd0);
    chk("rst_ready",   32'(req_ready), 32'd0);

    // Initial ctrl write after reset release
    PRESET = 1'b0;
    xfer("ctrl_init", 4'h4, 32'h1, 0, 4'b0000, 4'b0000, 1'b0);
    chk("ctrl_init_fnd_en", 32'(fnd_en), 32'd1);

    // Single client 2
    req_valid = 4'b0100;
    req_data[32 +: 16] = 16'h1234;
    xfer("c2_only", 4'h0, 32'h0000_1234, 2, 4'b0100, 4'b0100, 1'b0);

    // Reset, then all four clients continuously valid: ctrl first, then 0,1,2,3,0
    PRESET = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) req_data[16*i +: 16] = 16'hA000 + 16'(i);
    @(negedge PCLK);
    PRESET = 1'b0;
    xfer("rot_ctrl", 4'h4, 32'h1, 0, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++)
      xfer("rot", 4'h0, 32'hA000 + 32'(i % 4), i % 4, 4'(1 << (i % 4)), 4'b0000, 1'b0);

    // disp_en 1->0 during client 1 ACCESS; client 3 waits behind the ctrl write
    req_valid = 4'b1010;
    req_data[16 +: 16] = 16'hB001;
    req_data[48 +: 16] = 16'hB003;
    xfer("en_c1", 4'h0, 32'h0000_B001, 1, 4'b0010, 4'b0010, 1'b1);
    xfer("en_ctrl", 4'h4, 32'h0, 0, 4'b0000, 4'b0000, 1'b0);
    chk("en_ctrl_fnd_en", 32'(fnd_en), 32'd0);
    xfer("en_c3", 4'h0, 32'h0000_B003, 3, 4'b1000, 4'b1000, 1'b0);

    // PREADY stuck low: timeout after 16 ACCESS cycles
    hold = 1'b1;
    req_valid = 4'b0001;
    req_data[0 +: 16] = 16'hC000;
    @(negedge PCLK);
    chk("to_c1_psel",   32'(PSEL), 32'd1);
    chk("to_c1_pwdata", PWDATA, 32'h0000_C000);
    chk("to_c1_grant",  32'(grant_id), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge PCLK);
      chk("to_acc_penable", 32'(PENABLE), 32'd1);
      chk("to_acc_err",     32'(err), 32'd0);
      chk("to_acc_ready",   32'(req_ready), 32'd0);
    end
    @(negedge PCLK);
    chk("to_err",   32'(err), 32'd1);
    chk("to_psel",  32'(PSEL), 32'd0);
    chk("to_busy",  32'(busy), 32'd0);
    chk("to_ready", 32'(req_ready), 32'd0);
    // Pointer moved past 0, so client 2 goes before the retry of client 0
    hold = 1'b0;
    req_valid = 4'b0101;
    req_data[32 +: 16] = 16'hC002;
    xfer("to_c2", 4'h0, 32'h0000_C002, 2, 4'b0100, 4'b0100, 1'b0);
    xfer("to_retry_c0", 4'h0, 32'h0000_C000, 0, 4'b0001, 4'b0001, 1'b0);

    // Reset during SETUP of a data write
    req_valid = 4'b0010;
    req_data[16 +: 16] = 16'hD001;
    @(negedge PCLK);
    chk("mr_setup_psel",    32'(PSEL), 32'd1);
    chk("mr_setup_penable", 32'(PENABLE), 32'd0);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("mr_psel",    32'(PSEL), 32'd0);
    chk("mr_penable", 32'(PENABLE), 32'd0);
    chk("mr_busy",    32'(busy), 32'd0);
    chk("mr_paddr",   32'(PADDR), 32'd0);
    PRESET = 1'b0;
    xfer("mr_ctrl", 4'h4, 32'h0, 0, 4'b0000, 4'b0000, 1'b0);
    xfer("mr_c1", 4'h0, 32'h0000_D001, 1, 4'b0010, 4'b0010, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
